// File: rtl/shift_sequencer_pkg.sv
// Shared opcode and FSM state encodings for the shift sequencer and its requesters.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ROL = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_P1   = 2'b01,
    ST_P2   = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Rotates take a second pass; op[0] picks the first-pass direction.
  function automatic logic is_rotate(input op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/n_bit_shifter.sv
// Combinational logical shifter: ctrl 0 shifts left, ctrl 1 shifts right, zero fill.
module n_bit_shifter #(
  parameter int max_s_bits = 3,
  localparam int N = 2 ** max_s_bits
) (
  input  logic [N-1:0]          a,
  input  logic [max_s_bits-1:0] b,
  input  logic                  ctrl,
  output logic [N-1:0]          y
);

  assign y = ctrl ? (a >> b) : (a << b);

endmodule

// File: rtl/shift_sequencer.sv
// Round-robin sequencer sharing one logical shifter between two requesters;
// rotates are built from two opposite-direction passes ORed together.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int max_s_bits = 3,
  localparam int N = 2 ** max_s_bits
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [1:0]   op0,
  input  logic [1:0]   op1,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic         busy,
  output logic [N-1:0] result,
  output logic         done,
  output logic         done_id,
  output state_t       state
);

  // Handshake: req is a level held by the requester; ack is combinational and
  // only asserted in IDLE. The rising edge where req && ack are both high is the
  // transfer: operands are captured there and the requester may then drop req.

  op_t                   op_r;
  logic [N-1:0]          a_r;
  logic [max_s_bits-1:0] b_r;
  logic                  id_r;
  logic                  prio;
  logic [N-1:0]          acc;
  logic [N-1:0]          acc_next;

  logic [max_s_bits-1:0] sh_b;
  logic                  sh_ctrl;
  logic [N-1:0]          sh_y;

  logic unused_b_hi;
  assign unused_b_hi = ^{b0[N-1:max_s_bits], b1[N-1:max_s_bits]};

  // prio == 0 favours req0 on a tie, prio == 1 favours req1.
  assign ack0 = rst_n && (state == ST_IDLE) && req0 && (!req1 || !prio);
  assign ack1 = rst_n && (state == ST_IDLE) && req1 && (!req0 ||  prio);

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign done_id = done & id_r;

  // Second pass shifts the opposite way by (N - b) mod N to recover the wrapped bits.
  always_comb begin
    sh_b     = b_r;
    sh_ctrl  = op_r[0];
    acc_next = sh_y;
    if (state == ST_P2) begin
      sh_b     = '0 - b_r;
      sh_ctrl  = ~op_r[0];
      acc_next = acc | sh_y;
    end
  end

  n_bit_shifter #(.max_s_bits(max_s_bits)) u_shifter (
    .a    (a_r),
    .b    (sh_b),
    .ctrl (sh_ctrl),
    .y    (sh_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_r   <= OP_LSL;
      a_r    <= '0;
      b_r    <= '0;
      id_r   <= 1'b0;
      prio   <= 1'b0;
      acc    <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ack0 || ack1) begin
            op_r  <= ack1 ? op_t'(op1) : op_t'(op0);
            a_r   <= ack1 ? a1 : a0;
            b_r   <= ack1 ? b1[max_s_bits-1:0] : b0[max_s_bits-1:0];
            id_r  <= ack1;
            prio  <= ~ack1;
            state <= ST_P1;
          end
        end
        ST_P1: begin
          acc <= acc_next;
          if (is_rotate(op_r)) begin
            state <= ST_P2;
          end else begin
            result <= acc_next;
            state  <= ST_DONE;
          end
        end
        ST_P2: begin
          acc    <= acc_next;
          result <= acc_next;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: reset, arbitration, each opcode, masking, mid-op reset.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  localparam int MSB = 3;
  localparam int N   = 2 ** MSB;

  logic         clk;
  logic         rst_n;
  logic         req0, req1;
  logic [1:0]   op0, op1;
  logic [N-1:0] a0, a1, b0, b1;
  logic         ack0, ack1, busy, done, done_id;
  logic [N-1:0] result;
  state_t       state;

  int n_cmp;
  int n_bad;

  shift_sequencer #(.max_s_bits(MSB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .op0     (op0),
    .op1     (op1),
    .a0      (a0),
    .a1      (a1),
    .b0      (b0),
    .b1      (b1),
    .ack0    (ack0),
    .ack1    (ack1),
    .busy    (busy),
    .result  (result),
    .done    (done),
    .done_id (done_id),
    .state   (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one request on side id, check ack, latency, result and done_id.
  task automatic run_op(input string tag, input logic id, input logic [1:0] op,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp, input int exp_lat);
    int  n;
    logic got;
    @(posedge clk); #1;
    if (id) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    @(negedge clk);
    check_eq({tag, "_ack"}, {30'd0, ack1, ack0}, id ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = N'($urandom_range(0, 255)); a1 = N'($urandom_range(0, 255));
    b0 = N'($urandom_range(0, 255)); b1 = N'($urandom_range(0, 255));
    op0 = 2'($urandom_range(0, 3));  op1 = 2'($urandom_range(0, 3));
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    end
    check_eq({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check_eq({tag, "_latency"}, n, exp_lat);
    check_eq({tag, "_result"}, result, exp);
    check_eq({tag, "_done_id"}, {31'd0, done_id}, {31'd0, id});
    check_eq({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_result_hold"}, result, exp);
  endtask

  // Both requesters held high: grants must alternate and never appear while busy.
  task automatic run_round_robin();
    logic [N-1:0] exp_q[$];
    logic         exp_id_q[$];
    logic         got;
    int           n;
    for (int k = 0; k < 4; k++) begin
      exp_id_q.push_back(k[0]);
      exp_q.push_back(k[0] ? 8'h4B : 8'h3C);
    end
    @(posedge clk); #1;
    req0 = 1'b1; op0 = OP_LSL; a0 = 8'h0F; b0 = 8'h02;
    req1 = 1'b1; op1 = OP_ROR; a1 = 8'h96; b1 = 8'h01;
    for (int k = 0; k < 4; k++) begin
      logic exp_id;
      logic [N-1:0] exp_r;
      exp_id = exp_id_q.pop_front();
      exp_r  = exp_q.pop_front();
      @(negedge clk);
      check_eq("rr_grant", {30'd0, ack1, ack0}, exp_id ? 32'd2 : 32'd1);
      n = 0;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        @(negedge clk);
        n++;
        if (done) got = 1'b1;
        else check_eq("rr_no_ack_busy", {30'd0, ack1, ack0}, 32'd0);
      end
      check_eq("rr_done_seen", {31'd0, got}, 32'd1);
      check_eq("rr_no_ack_done", {30'd0, ack1, ack0}, 32'd0);
      check_eq("rr_latency", n, exp_id ? 32'd3 : 32'd2);
      check_eq("rr_done_id", {31'd0, done_id}, {31'd0, exp_id});
      check_eq("rr_result", result, exp_r);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    op0 = 2'b00; op1 = 2'b00;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_result", result, 32'h00);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_state", {30'd0, state}, {30'd0, ST_IDLE});

    run_round_robin();

    run_op("lsl",     1'b0, OP_LSL, 8'h0F, 8'h02, 8'h3C, 2);
    run_op("rol3",    1'b1, OP_ROL, 8'h96, 8'h03, 8'hB4, 3);
    run_op("ror1",    1'b0, OP_ROR, 8'h96, 8'h01, 8'h4B, 3);
    run_op("rol0",    1'b1, OP_ROL, 8'h96, 8'h00, 8'h96, 3);
    run_op("lsr_msk", 1'b0, OP_LSR, 8'h80, 8'h0F, 8'h01, 2);
    run_op("ror5",    1'b1, OP_ROR, 8'h81, 8'h05, 8'h0C, 3);

    // Reset during P2 of a rotate: the op must vanish without a done pulse.
    @(posedge clk); #1;
    req0 = 1'b1; op0 = OP_ROL; a0 = 8'h96; b0 = 8'h03;
    @(negedge clk);
    check_eq("mid_ack", {31'd0, ack0}, 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    check_eq("mid_p1", {30'd0, state}, {30'd0, ST_P1});
    @(posedge clk); #1;
    check_eq("mid_p2", {30'd0, state}, {30'd0, ST_P2});
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_ack", {30'd0, ack1, ack0}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("mid_state", {30'd0, state}, {30'd0, ST_IDLE});
    check_eq("mid_result", result, 32'h00);
    check_eq("mid_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("mid_no_done", {31'd0, done}, 32'd0);
    end

    run_op("post_rst", 1'b1, OP_LSL, 8'h01, 8'h07, 8'h80, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
